// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C target.
// State encoding is fixed so legacy code can compare against raw 3-bit values.
package i2c_pkg;
  localparam int I2C_ADDR_W = 7;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP
  } i2c_slv_state_t;
endpackage

// File: rtl/i2c_slave_if.sv
// Byte-side interface between the I2C target and on-chip logic.
// tx_data must be stable from the tx_req pulse until the following SCL fall.
interface i2c_slave_if;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       rnw;
  logic       busy;

  modport slave  (input tx_data, output rx_data, rx_valid, tx_req, rnw, busy);
  modport master (output tx_data, input rx_data, rx_valid, tx_req, rnw, busy);
endinterface

// File: rtl/i2c_slave_sync_edge.sv
// Multi-flop synchronizer for one bus line plus rise/fall pulses.
// Flops preset to 1 so an idle (pulled-up) bus produces no edge out of reset.
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_in,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;
endmodule

// File: rtl/i2c_slave.sv
// Single-address 7-bit I2C target, oversampled by clk, never stretches SCL.
// SDA is only ever changed on SCL fall, so the target cannot fake START/STOP.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLV_ADDR    = 7'h50,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  i2c_slave_if.slave bus
);
  localparam logic [2:0] S_IDLE      = IDLE;
  localparam logic [2:0] S_ADDR      = ADDR;
  localparam logic [2:0] S_ADDR_ACK  = ADDR_ACK;
  localparam logic [2:0] S_WRITE     = WRITE;
  localparam logic [2:0] S_WRITE_ACK = WRITE_ACK;
  localparam logic [2:0] S_READ      = READ;
  localparam logic [2:0] S_READ_ACK  = READ_ACK;

  logic       w_scl, w_scl_rise, w_scl_fall;
  logic       w_sda, w_sda_rise, w_sda_fall;
  logic       w_start, w_stop;
  logic [7:0] w_shift_in;

  logic [2:0] r_state;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_sda_oe;
  logic       r_byte_done;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_tx_req;
  logic       r_rnw;
  logic       r_busy;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .i_clk(clk), .i_rst_n(rst_n), .i_in(scl),
    .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .i_clk(clk), .i_rst_n(rst_n), .i_in(sda),
    .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
  );

  assign w_start    = w_scl & w_sda_fall;
  assign w_stop     = w_scl & w_sda_rise;
  assign w_shift_in = {r_shift[6:0], w_sda};
  assign sda        = r_sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 3'd7;
      r_shift     <= 8'h00;
      r_sda_oe    <= 1'b0;
      r_byte_done <= 1'b0;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_tx_req    <= 1'b0;
      r_rnw       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      if (w_start) begin
        r_state     <= S_ADDR;
        r_bit_cnt   <= 3'd7;
        r_sda_oe    <= 1'b0;
        r_byte_done <= 1'b0;
      end else if (w_stop) begin
        r_state     <= S_IDLE;
        r_sda_oe    <= 1'b0;
        r_busy      <= 1'b0;
        r_byte_done <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR, S_WRITE: begin
            // bit_cnt wraps 0->7 on the 8th rise, ready for the next byte
            if (w_scl_rise && !r_byte_done) begin
              r_shift   <= w_shift_in;
              r_bit_cnt <= r_bit_cnt - 3'd1;
              if (r_bit_cnt == 3'd0) begin
                r_byte_done <= 1'b1;
                if (r_state == S_WRITE) begin
                  r_rx_data  <= w_shift_in;
                  r_rx_valid <= 1'b1;
                end
              end
            end else if (w_scl_fall && r_byte_done) begin
              r_byte_done <= 1'b0;
              if (r_state == S_WRITE) begin
                r_sda_oe <= 1'b1;
                r_state  <= S_WRITE_ACK;
              end else if (r_shift[7:1] == SLV_ADDR) begin
                r_sda_oe <= 1'b1;
                r_rnw    <= r_shift[0];
                r_busy   <= 1'b1;
                r_tx_req <= r_shift[0];
                r_state  <= S_ADDR_ACK;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              r_bit_cnt <= 3'd7;
              if (r_rnw) begin
                r_shift  <= bus.tx_data;
                r_sda_oe <= ~bus.tx_data[7];
                r_state  <= S_READ;
              end else begin
                r_sda_oe <= 1'b0;
                r_state  <= S_WRITE;
              end
            end
          end
          S_WRITE_ACK: begin
            if (w_scl_fall) begin
              r_sda_oe  <= 1'b0;
              r_bit_cnt <= 3'd7;
              r_state   <= S_WRITE;
            end
          end
          S_READ: begin
            if (w_scl_fall) begin
              if (r_bit_cnt == 3'd0) begin
                r_sda_oe <= 1'b0;
                r_state  <= S_READ_ACK;
              end else begin
                r_bit_cnt <= r_bit_cnt - 3'd1;
                r_shift   <= {r_shift[6:0], 1'b0};
                r_sda_oe  <= ~r_shift[6];
              end
            end
          end
          S_READ_ACK: begin
            // byte_done here marks "master ACKed, reload on the next fall"
            if (w_scl_rise) begin
              if (!w_sda) begin
                r_tx_req    <= 1'b1;
                r_byte_done <= 1'b1;
              end else begin
                r_busy  <= 1'b0;
                r_state <= WAIT_STOP;
              end
            end else if (w_scl_fall && r_byte_done) begin
              r_byte_done <= 1'b0;
              r_bit_cnt   <= 3'd7;
              r_shift     <= bus.tx_data;
              r_sda_oe    <= ~bus.tx_data[7];
              r_state     <= S_READ;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign bus.tx_req   = r_tx_req;
  assign bus.rnw      = r_rnw;
  assign bus.busy     = r_busy;
endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench: bit-banged I2C master against i2c_slave at address 0x50.
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam int Q = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic m_scl;
  logic m_sda_low;
  wire  sda;

  i2c_slave_if bus();

  logic [7:0] tx_tab [16];
  int         tx_req_cnt = 0;
  int         rx_cnt     = 0;
  int         drv_cnt    = 0;
  int         both_cnt   = 0;
  logic [3:0] tx_idx;

  int n_cmp = 0;
  int n_bad = 0;

  assign tx_idx      = 4'(tx_req_cnt - 1);
  assign bus.tx_data = tx_tab[tx_idx];
  assign sda         = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_slave #(.SLV_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .scl(m_scl), .sda(sda), .bus(bus)
  );

  always @(negedge clk) begin
    if (bus.rx_valid) rx_cnt <= rx_cnt + 1;
    if (bus.tx_req) tx_req_cnt <= tx_req_cnt + 1;
    if (bus.rx_valid && bus.tx_req) both_cnt <= both_cnt + 1;
    if (sda === 1'b0 && !m_sda_low) drv_cnt <= drv_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    m_sda_low = ~b;
    wq();
    m_scl = 1'b1;
    wq();
    s = sda;
    wq();
    m_scl = 1'b0;
    wq();
  endtask

  task automatic start_c();
    m_sda_low = 1'b0;
    wq();
    m_scl = 1'b1;
    wq();
    m_sda_low = 1'b1;
    wq();
    m_scl = 1'b0;
    wq();
  endtask

  task automatic stop_c();
    m_sda_low = 1'b1;
    wq();
    m_scl = 1'b1;
    wq();
    m_sda_low = 1'b0;
    wq();
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
    bit_xfer(1'b1, ack);
  endtask

  // ack_bit: 0 = master ACKs, 1 = master NACKs; s9 is the line seen in the 9th clock
  task automatic rd_byte(input logic ack_bit, output logic [7:0] d, output logic s9);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      d[i] = s;
    end
    bit_xfer(ack_bit, s9);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    logic       a;
    logic       s;
    logic [7:0] d;
    logic [7:0] ab;
    int         rx0, tx0, dr0;

    for (int i = 0; i < 16; i++) tx_tab[i] = 8'h00;
    rst_n     = 1'b0;
    m_scl     = 1'b1;
    m_sda_low = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_sda", sda, 1'b1);
    chk("rst_rx_data", bus.rx_data, 8'h00);
    chk("rst_rx_valid", bus.rx_valid, 1'b0);
    chk("rst_tx_req", bus.tx_req, 1'b0);
    chk("rst_rnw", bus.rnw, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    wq();

    // write 0xA5 to 0x50
    rx0 = rx_cnt;
    start_c();
    wr_byte(8'hA0, a);
    chk("t1_addr_ack", a, 1'b0);
    chk("t1_busy", bus.busy, 1'b1);
    chk("t1_rnw", bus.rnw, 1'b0);
    wr_byte(8'hA5, a);
    chk("t1_data_ack", a, 1'b0);
    chk("t1_rx_data", bus.rx_data, 8'hA5);
    chk("t1_rx_valid_cnt", rx_cnt - rx0, 1);
    stop_c();
    chk("t1_busy_after_stop", bus.busy, 1'b0);

    // wrong address 0x51
    rx0 = rx_cnt; tx0 = tx_req_cnt; dr0 = drv_cnt;
    start_c();
    wr_byte(8'hA2, a);
    chk("t2_addr_nack", a, 1'b1);
    chk("t2_busy", bus.busy, 1'b0);
    stop_c();
    chk("t2_drive_cnt", drv_cnt - dr0, 0);
    chk("t2_rx_valid_cnt", rx_cnt - rx0, 0);
    chk("t2_tx_req_cnt", tx_req_cnt - tx0, 0);

    // single-byte read, master NACK
    tx_tab[4'(tx_req_cnt)] = 8'h3C;
    tx0 = tx_req_cnt;
    start_c();
    wr_byte(8'hA1, a);
    chk("t3_addr_ack", a, 1'b0);
    chk("t3_rnw", bus.rnw, 1'b1);
    rd_byte(1'b1, d, a);
    chk("t3_byte", d, 8'h3C);
    chk("t3_ninth_released", a, 1'b1);
    chk("t3_state", dut.r_state, WAIT_STOP);
    chk("t3_busy", bus.busy, 1'b0);
    chk("t3_tx_req_cnt", tx_req_cnt - tx0, 1);
    stop_c();

    // two-byte read, ACK then NACK
    tx_tab[4'(tx_req_cnt)]     = 8'h3C;
    tx_tab[4'(tx_req_cnt + 1)] = 8'hC3;
    tx0 = tx_req_cnt;
    start_c();
    wr_byte(8'hA1, a);
    chk("t4_addr_ack", a, 1'b0);
    rd_byte(1'b0, d, a);
    chk("t4_byte0", d, 8'h3C);
    rd_byte(1'b1, d, a);
    chk("t4_byte1", d, 8'hC3);
    chk("t4_ninth_released", a, 1'b1);
    dr0 = drv_cnt;
    stop_c();
    wq();
    chk("t4_drive_after", drv_cnt - dr0, 0);
    chk("t4_tx_req_cnt", tx_req_cnt - tx0, 2);

    // repeated START after 4 bits of a write byte, then read
    tx_tab[4'(tx_req_cnt)] = 8'h5A;
    rx0 = rx_cnt;
    start_c();
    wr_byte(8'hA0, a);
    chk("t5_wr_addr_ack", a, 1'b0);
    for (int i = 0; i < 4; i++) bit_xfer(1'b1, s);
    start_c();
    wr_byte(8'hA1, a);
    chk("t5_rd_addr_ack", a, 1'b0);
    chk("t5_rnw", bus.rnw, 1'b1);
    rd_byte(1'b1, d, a);
    chk("t5_byte", d, 8'h5A);
    stop_c();
    chk("t5_rx_valid_cnt", rx_cnt - rx0, 0);

    // reset pulse while the target drives the address ACK
    ab = 8'hA0;
    start_c();
    for (int i = 7; i >= 0; i--) bit_xfer(ab[i], s);
    m_sda_low = 1'b0;
    wq();
    m_scl = 1'b1;
    wq();
    chk("t6_ack_driven", sda, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_sda_released", sda, 1'b1);
    chk("t6_busy", bus.busy, 1'b0);
    chk("t6_rx_data", bus.rx_data, 8'h00);
    chk("t6_rnw", bus.rnw, 1'b0);
    rst_n = 1'b1;
    wq();
    m_scl = 1'b0;
    wq();
    stop_c();
    start_c();
    wr_byte(8'hA0, a);
    chk("t6_addr_ack_after_rst", a, 1'b0);
    wr_byte(8'h77, a);
    chk("t6_data_ack", a, 1'b0);
    chk("t6_rx_data_after", bus.rx_data, 8'h77);
    stop_c();

    chk("no_rx_tx_overlap", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
